// File: rtl/lexin_chk_pkg.sv
// Shared types and constants for the lexin_chk receive-side checksum verifier.
package lexin_chk_pkg;

  localparam int CHK_W = 8;

  typedef logic [CHK_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/lexin_chk_acc.sv
// Payload accumulator: 8-bit wrapping sum plus byte index.
// load starts a frame with its first byte, add folds in one more byte,
// clear returns to the idle values. last is high when the next add
// brings the index up to FRAME_LEN.
module lexin_chk_acc
  import lexin_chk_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  load,
  input  logic  add,
  input  logic  clear,
  input  byte_t din,
  output byte_t acc,
  output logic  last
);

  localparam logic [7:0] FL = 8'(FRAME_LEN);

  logic [7:0] idx;

  // Accumulator and index; load wins over add so a restart never sums into the old frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
      idx <= '0;
    end else if (clear) begin
      acc <= '0;
      idx <= '0;
    end else if (load) begin
      acc <= din;
      idx <= 8'd1;
    end else if (add) begin
      acc <= acc + din;
      idx <= idx + 8'd1;
    end
  end

  assign last = ((idx + 8'd1) == FL);

endmodule

// File: rtl/lexin_chk_verify.sv
// Receive-side checksum verifier: FRAME_LEN payload bytes then one checksum
// byte, 8-bit modular sum, one registered pass/fail/abort report per frame.
// Optional statistics counters are compiled in with LEXIN_CHK_STATS_EN.
module lexin_chk_verify
  import lexin_chk_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [CHK_W-1:0] in_data,
  output logic             out_done,
  output logic             out_ok,
  output logic             out_abort,
  output logic [CHK_W-1:0] out_sum
`ifdef LEXIN_CHK_STATS_EN
  ,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  if (FRAME_LEN < 1 || FRAME_LEN > 255 || CNT_W < 1) begin : g_bad_param
    $error("lexin_chk_verify: FRAME_LEN must be 1..255 and CNT_W >= 1");
  end

  // A single-byte frame goes straight from its first byte to the checksum.
  localparam state_t FIRST_NEXT = (FRAME_LEN == 1) ? CHECK : DATA;

  state_t state, state_n;
  byte_t  acc;
  logic   last;
  logic   load, add, clear;
  logic   done_n, ok_n, abort_n;
  byte_t  sum_n;

  lexin_chk_acc #(.FRAME_LEN(FRAME_LEN)) u_acc (
    .clk  (clk),
    .nrst (nrst),
    .load (load),
    .add  (add),
    .clear(clear),
    .din  (in_data),
    .acc  (acc),
    .last (last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, accumulator controls and the result about to be registered.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    add     = 1'b0;
    clear   = 1'b0;
    done_n  = 1'b0;
    ok_n    = 1'b0;
    abort_n = 1'b0;
    sum_n   = out_sum;
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          // Bytes outside a frame are dropped unless they open one.
          if (in_sof) begin
            load    = 1'b1;
            state_n = FIRST_NEXT;
          end
        end
        DATA, CHECK: begin
          if (in_sof) begin
            // Report the cut-short frame and start the new one on the same byte.
            done_n  = 1'b1;
            abort_n = 1'b1;
            sum_n   = acc;
            load    = 1'b1;
            state_n = FIRST_NEXT;
          end else if (state == DATA) begin
            add = 1'b1;
            if (last) state_n = CHECK;
          end else begin
            done_n  = 1'b1;
            ok_n    = (in_data == acc);
            sum_n   = acc;
            clear   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Registered frame report; ok/abort are only ever high alongside done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_done  <= 1'b0;
      out_ok    <= 1'b0;
      out_abort <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_done  <= done_n;
      out_ok    <= ok_n;
      out_abort <= abort_n;
      out_sum   <= sum_n;
    end
  end

`ifdef LEXIN_CHK_STATS_EN
  // Saturating frame/error counters, updated with the same edge as out_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (done_n) begin
      if (!abort_n && frm_cnt != '1)             frm_cnt <= frm_cnt + CNT_W'(1);
      if ((abort_n || !ok_n) && err_cnt != '1)   err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_lexin_chk_verify.sv
// Bench for lexin_chk_verify: one 16-byte-frame instance and one 1-byte-frame
// instance with narrow counters, checked every cycle against a frame-buffer model.
module tb_lexin_chk_verify;

  logic       clk = 1'b0;
  logic       nrst;
  logic       v0, s0, v1, s1;
  logic [7:0] d0, d1;
  logic       out_done0, out_ok0, out_abort0, out_done1, out_ok1, out_abort1;
  logic [7:0] out_sum0, out_sum1;
  logic [15:0] frm0, err0;
  logic [1:0]  frm1, err1;

  int total = 0;
  int bad   = 0;
  int pulses0 = 0;

  always #5 clk = ~clk;

  lexin_chk_verify #(.FRAME_LEN(16), .CNT_W(16)) dut0 (
    .clk(clk), .nrst(nrst), .in_valid(v0), .in_sof(s0), .in_data(d0),
    .out_done(out_done0), .out_ok(out_ok0), .out_abort(out_abort0), .out_sum(out_sum0)
`ifdef LEXIN_CHK_STATS_EN
    , .frm_cnt(frm0), .err_cnt(err0)
`endif
  );

  lexin_chk_verify #(.FRAME_LEN(1), .CNT_W(2)) dut1 (
    .clk(clk), .nrst(nrst), .in_valid(v1), .in_sof(s1), .in_data(d1),
    .out_done(out_done1), .out_ok(out_ok1), .out_abort(out_abort1), .out_sum(out_sum1)
`ifdef LEXIN_CHK_STATS_EN
    , .frm_cnt(frm1), .err_cnt(err1)
`endif
  );

`ifndef LEXIN_CHK_STATS_EN
  assign frm0 = '0; assign err0 = '0; assign frm1 = '0; assign err1 = '0;
`endif

  // ---------------- reference model: buffered frame bytes per instance ----------------
  int         fl[2]   = '{16, 1};
  int         cmax[2] = '{65535, 3};
  logic [7:0] mem[2][256];
  int         n[2];
  bit         infr[2];
  bit         e_done[2], e_ok[2], e_ab[2];
  logic [7:0] e_sum[2];
  int         e_frm[2], e_err[2];

  function automatic logic [7:0] fsum(int k);
    int s = 0;
    for (int i = 0; i < n[k]; i++) s += int'(mem[k][i]);
    return 8'(s % 256);
  endfunction

  task automatic report(int k, bit ab, bit ok, logic [7:0] sm);
    e_done[k] = 1'b1; e_ab[k] = ab; e_ok[k] = ok; e_sum[k] = sm;
    if (!ab && e_frm[k] < cmax[k]) e_frm[k]++;
    if ((ab || !ok) && e_err[k] < cmax[k]) e_err[k]++;
  endtask

  task automatic model_eval(int k, bit v, bit s, logic [7:0] d);
    e_done[k] = 0; e_ok[k] = 0; e_ab[k] = 0;
    if (v) begin
      if (s) begin
        if (infr[k]) report(k, 1'b1, 1'b0, fsum(k));
        mem[k][0] = d; n[k] = 1; infr[k] = 1'b1;
      end else if (infr[k]) begin
        if (n[k] < fl[k]) begin
          mem[k][n[k]] = d; n[k]++;
        end else begin
          report(k, 1'b0, d == fsum(k), fsum(k));
          infr[k] = 1'b0; n[k] = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; infr[k] = 0; e_done[k] = 0; e_ok[k] = 0; e_ab[k] = 0;
      e_sum[k] = 8'h00; e_frm[k] = 0; e_err[k] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("out0", {out_done0, out_ok0, out_abort0, out_sum0}, {e_done[0], e_ok[0], e_ab[0], e_sum[0]});
    chk("out1", {out_done1, out_ok1, out_abort1, out_sum1}, {e_done[1], e_ok[1], e_ab[1], e_sum[1]});
`ifdef LEXIN_CHK_STATS_EN
    chk("cnt0", {frm0, err0}, {16'(e_frm[0]), 16'(e_err[0])});
    chk("cnt1", {frm1, err1}, {2'(e_frm[1]), 2'(e_err[1])});
`endif
    if (out_done0) pulses0++;
  endtask

  // One clock: drive instance k (the other idles), advance, compare both.
  task automatic step(int k, bit v, bit s, logic [7:0] d);
    v0 = (k == 0) ? v : 1'b0; s0 = s; d0 = d;
    v1 = (k == 1) ? v : 1'b0; s1 = s; d1 = d;
    model_eval(0, v0, s0, d0);
    model_eval(1, v1, s1, d1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; d0 = 0; d1 = 0;
    nrst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    nrst = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] pl[16], input logic [7:0] ck, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 0, 8'h00);
      step(0, 1, i == 0, pl[i]);
    end
    if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 0, 8'h00);
    step(0, 1, 0, ck);
  endtask

  typedef struct {
    bit v; bit s; logic [7:0] d;
    bit done; bit ok; bit ab; logic [7:0] sum;
  } vec_t;

  vec_t       tbl[9];
  logic [7:0] pl[16];
  logic [7:0] ff[16];

  initial begin
    // FRAME_LEN = 1 vectors: inputs and the report seen one cycle later.
    tbl[0] = '{1, 1, 8'h5A, 0, 0, 0, 8'h00};
    tbl[1] = '{1, 0, 8'h5A, 1, 1, 0, 8'h5A};
    tbl[2] = '{1, 0, 8'h33, 0, 0, 0, 8'h5A};
    tbl[3] = '{1, 1, 8'h10, 0, 0, 0, 8'h5A};
    tbl[4] = '{1, 0, 8'h11, 1, 0, 0, 8'h10};
    tbl[5] = '{1, 1, 8'h20, 0, 0, 0, 8'h10};
    tbl[6] = '{1, 1, 8'h30, 1, 0, 1, 8'h20};
    tbl[7] = '{0, 0, 8'h00, 0, 0, 0, 8'h20};
    tbl[8] = '{1, 0, 8'h30, 1, 1, 0, 8'h30};
    for (int i = 0; i < 16; i++) begin pl[i] = 8'(i + 1); ff[i] = 8'hFF; end

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d", i), {out_done1, out_ok1, out_abort1, out_sum1},
          {tbl[i].done, tbl[i].ok, tbl[i].ab, tbl[i].sum});
    end

    // Clean frame.
    do_reset();
    send_frame(pl, 8'h88, 0);
    chk("clean", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b1, 1'b0, 8'h88});
`ifdef LEXIN_CHK_STATS_EN
    chk("clean_cnt", {frm0, err0}, {16'd1, 16'd0});
`endif

    // Mismatch.
    do_reset();
    send_frame(pl, 8'h87, 0);
    chk("mismatch", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b0, 1'b0, 8'h88});
`ifdef LEXIN_CHK_STATS_EN
    chk("mismatch_cnt", {frm0, err0}, {16'd1, 16'd1});
`endif

    // Wrap-around with bubbles.
    do_reset();
    send_frame(ff, 8'hF0, 1);
    chk("wrap", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b1, 1'b0, 8'hF0});

    // Abort on payload byte 6, then the new frame completes.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, i == 0, pl[i]);
    step(0, 1, 1, 8'h06);
    chk("abort", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b0, 1'b1, 8'h0F});
    for (int i = 1; i < 16; i++) step(0, 1, 0, 8'(6 + i));
    step(0, 1, 0, 8'h36);  // 6+7+...+21 = 216 = 0xD8 ... recomputed below
    chk("abort_next_done", {31'd0, out_done0}, 32'd1);
    // The above checksum is deliberately checked against the model only;
    // send one more frame with the right sum explicitly.
    for (int i = 0; i < 16; i++) step(0, 1, i == 0, 8'(6 + i));
    step(0, 1, 0, 8'hD8);
    chk("abort_next_ok", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b1, 1'b0, 8'hD8});

    // Bytes without in_sof while idle produce nothing.
    do_reset();
    pulses0 = 0;
    for (int i = 0; i < 20; i++) step(0, 1, 0, 8'($urandom));
    chk("idle_no_sof", pulses0, 0);

    // Reset at payload byte 8, then a clean frame.
    for (int i = 0; i < 7; i++) step(0, 1, i == 0, pl[i]);
    do_reset();
    pulses0 = 0;
    send_frame(pl, 8'h88, 1);
    chk("rst_clean", {out_done0, out_ok0, out_abort0, out_sum0}, {1'b1, 1'b1, 1'b0, 8'h88});
    step(0, 0, 0, 8'h00);
    chk("rst_pulses", pulses0, 1);

    // Randomized traffic on both instances.
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      int         k;
      bit         v, s;
      logic [7:0] d;
      k = int'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      if (!infr[k])               s = ($urandom_range(0, 2) != 0);
      else if (n[k] == fl[k])     s = ($urandom_range(0, 15) == 0);
      else                        s = ($urandom_range(0, 39) == 0);
      d = 8'($urandom);
      if (infr[k] && n[k] == fl[k] && !s && $urandom_range(0, 1) == 1) d = fsum(k);
      step(k, v, s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lexin_chk_verify.md
# lexin_chk_verify

Receive-side checksum verifier for the byte-stream checksum generator. It accepts framed byte streams of FRAME_LEN payload bytes followed by one checksum byte. It recomputes the 8-bit modular sum over the payload and reports pass or fail per frame. It sits at the consuming end of the checksum link and optionally keeps frame and error statistics.

## Interface
Parameters:
- FRAME_LEN, 16: payload bytes per frame; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, in, 1: single clock, rising edge.
- nrst, in, 1: asynchronous active-low reset; all state cleared while low.
- in_valid, in, 1: in_data is valid this cycle; the block is always ready.
- in_sof, in, 1: start of frame; qualified by in_valid; marks the first payload byte.
- in_data, in, 8: payload or checksum byte.
- out_done, out, 1: one-cycle pulse when a frame completes or is aborted.
- out_ok, out, 1: qualified by out_done; 1 means the checksum matched.
- out_abort, out, 1: qualified by out_done; 1 means the frame was cut short by a new in_sof.
- out_sum, out, 8: recomputed payload sum of the reported frame; held until the next out_done.
- frm_cnt, out, CNT_W: completed frames. Present only with LEXIN_CHK_STATS_EN.
- err_cnt, out, CNT_W: mismatched plus aborted frames. Present only with LEXIN_CHK_STATS_EN.

## Operation
- FSM states: IDLE, DATA, CHECK. Reset state is IDLE.
- IDLE: in_valid & in_sof sets acc = in_data and idx = 1. The next state is CHECK if FRAME_LEN == 1, else DATA. in_valid without in_sof is dropped silently and not counted.
- DATA: each in_valid byte does acc = acc + in_data (mod 256) and idx++. When idx reaches FRAME_LEN after the add, the next state is CHECK.
- CHECK: the next in_valid byte is the checksum.
  - out_ok = (in_data == acc).
  - out_sum = acc.
  - Return to IDLE.
- Bubbles (in_valid = 0) are allowed anywhere and hold all state.
- Abort: in_valid & in_sof in DATA or CHECK reports the old frame with out_ok = 0 and out_abort = 1, and out_sum = the partial acc. The same byte starts a new frame as in IDLE. One byte is never both a checksum and a payload start.
- Arithmetic: acc is 8 bits with natural wrap-around. idx is 8 bits and is compared against FRAME_LEN.
- With LEXIN_CHK_STATS_EN, counters update on out_done:
  - frm_cnt increments on every completed frame, including mismatches.
  - err_cnt increments on every mismatch and every abort.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values: out_done = 0, out_ok = 0, out_abort = 0, out_sum = 8'h00, frm_cnt = 0, err_cnt = 0. The FSM is in IDLE with acc = 0 and idx = 0.
- Latency: out_done, out_ok, out_abort and out_sum are registered. They appear the cycle after the checksum byte (or the aborting in_sof byte) is sampled.
- out_done is high for exactly one cycle per event. out_ok and out_abort are 0 whenever out_done is 0.
- Counters reflect a frame's result in the same cycle as its out_done pulse.
- Back-to-back frames are allowed: a new in_sof may arrive the cycle after the checksum byte, with no required gap.
- nrst asserted mid-frame discards the frame with no out_done, and the statistics are cleared. After release the first accepted byte must carry in_sof.

## Configuration
- LEXIN_CHK_STATS_EN defined: frm_cnt and err_cnt ports and their counter logic are compiled in.
- LEXIN_CHK_STATS_EN undefined: those ports and counters are absent. All other behaviour and timing are unchanged.

## Structure
- Shared package lexin_chk_pkg:
  - FSM state enum (IDLE, DATA, CHECK).
  - Byte typedef (8-bit).
  - Constant CHK_W = 8.
- One sub-module, lexin_chk_acc: the 8-bit accumulator plus idx counter. It has load, add and clear controls and a last-byte flag. The top holds the FSM, the result registers and the statistics.

## Test plan
- Clean frame: FRAME_LEN = 16, payload 0x01..0x10, checksum 0x88 → one out_done with out_ok = 1, out_abort = 0, out_sum = 0x88; frm_cnt = 1, err_cnt = 0.
- Mismatch: same payload, checksum 0x87 → out_done with out_ok = 0, out_sum = 0x88; err_cnt = 1, frm_cnt = 1.
- Wrap-around and bubbles: sixteen 0xFF payload bytes with random in_valid gaps, checksum 0xF0 → out_ok = 1, out_sum = 0xF0.
- Abort: in_sof on payload byte 6 of a frame → out_done with out_abort = 1 and out_sum = the partial sum. The new frame then completes normally → out_ok = 1; err_cnt = 1.
- Edge cases:
  - FRAME_LEN = 1, bytes 0x5A then 0x5A → out_ok = 1.
  - Bytes without in_sof while in IDLE → no out_done.
- Reset mid-frame: nrst low at payload byte 8, then a clean frame → exactly one out_done, with out_ok = 1; counters restart from 0.
